prog_ram: RTL and testbench

Writable, parametrised program memory that replaces the fixed `prog` ROM in the embedded processor. The processor fetches instructions through a registered read port. A host streams a new program in through a valid/ready load port. Unwritten words are auto-filled with NOPs (all-zero), a load checksum is kept, and an on-demand integrity scan re-reads the whole memory and compares it against that checksum.

---
 rtl/prog_ram.sv | 146 ++++++++++++++
 tb/tb_prog_ram.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_ram.sv
// Writable program memory: registered fetch port, valid/ready program load with
// NOP auto-fill of unwritten words, load checksum and on-demand integrity scan.
module prog_ram #(
   parameter int unsigned p_size = 6,
   parameter int unsigned i_size = 24
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [p_size-1:0] address,
   output logic [i_size:0]   instr,
   output logic              ready,
   input  logic              load_start,
   input  logic              ld_valid,
   input  logic [i_size:0]   ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   input  logic              scan_start,
   output logic              done,
   output logic              scan_ok,
   output logic [i_size:0]   checksum,
   output logic [p_size:0]   word_count
);

   localparam int unsigned DEPTH = 1 << p_size;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL, S_SCAN} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [p_size-1:0] r_ptr;
   logic [i_size:0]   r_mem [DEPTH];
   logic [i_size:0]   r_rdata;
   logic [i_size:0]   r_acc;
   logic [i_size:0]   r_checksum;
   logic [p_size:0]   r_word_count;
   logic              r_scan_ok;
   logic              r_done;
   logic              r_scan_vld;
   logic              r_scan_end;

   logic              w_xfer;
   logic              w_ptr_last;
   logic              w_we;
   logic [i_size:0]   w_wdata;
   logic [p_size-1:0] w_raddr;
   logic [i_size:0]   w_acc_sum;

   assign w_xfer     = (r_state == S_LOAD) && ld_valid;
   assign w_ptr_last = (r_ptr == '1);
   assign w_we       = w_xfer || (r_state == S_FILL);
   assign w_wdata    = (r_state == S_LOAD) ? ld_data : '0;
   assign w_raddr    = (r_state == S_SCAN) ? r_ptr : address;
   assign w_acc_sum  = r_acc + r_rdata;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (load_start)      w_next = S_LOAD;
            else if (scan_start) w_next = S_SCAN;
         end
         S_LOAD: begin
            if (w_xfer) begin
               if (w_ptr_last)   w_next = S_IDLE;
               else if (ld_last) w_next = S_FILL;
            end
         end
         S_FILL: begin
            if (w_ptr_last) w_next = S_IDLE;
         end
         S_SCAN: begin
            if (r_scan_end) w_next = S_IDLE;
         end
         default: w_next = S_FILL;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) r_state <= S_FILL;
      else       r_state <= w_next;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_ptr        <= '0;
         r_checksum   <= '0;
         r_word_count <= '0;
         r_scan_ok    <= 1'b0;
         r_done       <= 1'b0;
         r_acc        <= '0;
         r_scan_vld   <= 1'b0;
         r_scan_end   <= 1'b0;
      end else begin
         r_done <= (r_state != S_IDLE) && (w_next == S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (load_start) begin
                  r_ptr        <= '0;
                  r_checksum   <= '0;
                  r_word_count <= '0;
                  r_scan_ok    <= 1'b0;
               end else if (scan_start) begin
                  r_ptr      <= '0;
                  r_acc      <= '0;
                  r_scan_vld <= 1'b0;
                  r_scan_end <= 1'b0;
               end
            end
            S_LOAD: begin
               if (w_xfer) begin
                  r_checksum   <= r_checksum + ld_data;
                  r_word_count <= r_word_count + 1'b1;
                  r_ptr        <= r_ptr + 1'b1;
               end
            end
            S_FILL: r_ptr <= r_ptr + 1'b1;
            S_SCAN: begin
               // read data lags the pointer by one cycle; the extra cycle adds the last word
               if (r_scan_vld) r_acc <= w_acc_sum;
               if (r_scan_end) begin
                  r_scan_ok <= (w_acc_sum == r_checksum);
               end else begin
                  r_ptr      <= r_ptr + 1'b1;
                  r_scan_vld <= 1'b1;
                  if (w_ptr_last) r_scan_end <= 1'b1;
               end
            end
            default: r_ptr <= '0;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (w_we) r_mem[r_ptr] <= w_wdata;
      r_rdata <= r_mem[w_raddr];
   end

   assign ready      = (r_state == S_IDLE);
   assign ld_ready   = (r_state == S_LOAD);
   assign instr      = ready ? r_rdata : '0;
   assign done       = r_done;
   assign scan_ok    = r_scan_ok;
   assign checksum   = r_checksum;
   assign word_count = r_word_count;

endmodule

// File: tb/tb_prog_ram.sv
// Self-checking bench for prog_ram: reset fill, short/full/stalled loads,
// integrity scan, reset abort and simultaneous start arbitration.
module tb_prog_ram;

   localparam int P     = 6;
   localparam int I     = 24;
   localparam int DEPTH = 64;

   logic         Clock = 1'b0;
   logic         Reset = 1'b1;
   logic [P-1:0] address = '0;
   logic [I:0]   instr;
   logic         ready;
   logic         load_start = 1'b0;
   logic         ld_valid = 1'b0;
   logic [I:0]   ld_data = '0;
   logic         ld_last = 1'b0;
   logic         ld_ready;
   logic         scan_start = 1'b0;
   logic         done;
   logic         scan_ok;
   logic [I:0]   checksum;
   logic [P:0]   word_count;

   int checks = 0;
   int errors = 0;

   logic [I:0] exp_mem [DEPTH];
   logic [I:0] exp_checksum;
   logic [P:0] exp_count;
   logic [I:0] sb_q [$];

   prog_ram #(.p_size(P), .i_size(I)) dut (
      .Clock(Clock), .Reset(Reset), .address(address), .instr(instr), .ready(ready),
      .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
      .ld_ready(ld_ready), .scan_start(scan_start), .done(done), .scan_ok(scan_ok),
      .checksum(checksum), .word_count(word_count)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Counts non-IDLE cycles (bounded) and notes any non-zero instr seen meanwhile.
   task automatic wait_idle(output int n, output logic nz);
      n  = 0;
      nz = 1'b0;
      while (!ready && n < 200) begin
         if (instr !== '0) nz = 1'b1;
         n++;
         tick();
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      exp_checksum = '0;
      exp_count    = '0;
   endtask

   task automatic model_write(input logic [I:0] d);
      exp_mem[exp_count[P-1:0]] = d;
      exp_checksum = exp_checksum + d;
      exp_count    = exp_count + 1'b1;
   endtask

   // back-to-back fetches: sweep 0..63 then 16 random addresses
   task automatic test_fetch(input string tag);
      logic [I:0]   exp;
      logic [P-1:0] a;
      for (int i = 0; i < DEPTH + 16; i++) begin
         a = (i < DEPTH) ? P'(i) : P'($urandom_range(DEPTH - 1));
         address = a;
         sb_q.push_back(exp_mem[a]);
         tick();
         exp = sb_q.pop_front();
         checks++;
         if (instr !== exp || ready !== 1'b1) begin
            errors++;
            $display("FAIL %s fetch addr %0d: instr=%h ready=%b expected %h ready=1", tag, a, instr, ready, exp);
         end
      end
   endtask

   task automatic test_reset();
      int   n;
      logic nz;
      Reset = 1'b1;
      tick();
      checks++;
      if (ready !== 1'b0 || done !== 1'b0 || ld_ready !== 1'b0 || instr !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b done=%b ld_ready=%b instr=%h expected 0 0 0 0", ready, done, ld_ready, instr);
      end
      checks++;
      if (checksum !== '0 || word_count !== '0 || scan_ok !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs: checksum=%h word_count=%0d scan_ok=%b expected 0 0 0", checksum, word_count, scan_ok);
      end
      Reset = 1'b0;
      wait_idle(n, nz);
      checks++;
      if (n != 64 || nz) begin
         errors++;
         $display("FAIL reset_fill_len: cycles=%0d instr_nonzero=%b expected 64 0", n, nz);
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL reset_done: done=%b expected 1", done);
      end
      model_clear();
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL reset_done_pulse: done=%b expected 0", done);
      end
      test_fetch("reset");
   endtask

   task automatic test_short_load();
      int         n;
      logic       nz;
      logic [I:0] w [3];
      w[0] = 25'h0000001; w[1] = 25'h0123456; w[2] = 25'h1FFFFFF;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      checks++;
      if (ld_ready !== 1'b1 || ready !== 1'b0) begin
         errors++;
         $display("FAIL short_enter_load: ld_ready=%b ready=%b expected 1 0", ld_ready, ready);
      end
      model_clear();
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1;
         ld_data  = w[i];
         ld_last  = (i == 2);
         tick();
         model_write(w[i]);
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      wait_idle(n, nz);
      checks++;
      if (n != 61 || done !== 1'b1) begin
         errors++;
         $display("FAIL short_fill_len: cycles=%0d done=%b expected 61 1", n, done);
      end
      checks++;
      if (checksum !== 25'h0123456 || word_count !== 7'd3) begin
         errors++;
         $display("FAIL short_sum: checksum=%h word_count=%0d expected 0123456 3", checksum, word_count);
      end
      test_fetch("short_load");
   endtask

   task automatic test_full_load();
      logic stall_bad = 1'b0;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         if (ld_ready !== 1'b1) stall_bad = 1'b1;
         ld_valid = 1'b1;
         ld_data  = 25'(i);
         tick();
         model_write(25'(i));
      end
      checks++;
      if (stall_bad) begin
         errors++;
         $display("FAIL full_ld_ready: ld_ready=0 during load expected 1");
      end
      ld_data = 25'h1555555;
      checks++;
      if (ready !== 1'b1 || done !== 1'b1 || ld_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_end: ready=%b done=%b ld_ready=%b expected 1 1 0", ready, done, ld_ready);
      end
      tick();
      ld_valid = 1'b0;
      checks++;
      if (checksum !== 25'h00007E0 || word_count !== 7'd64) begin
         errors++;
         $display("FAIL full_sum: checksum=%h word_count=%0d expected 00007e0 64", checksum, word_count);
      end
      test_fetch("full_load");
   endtask

   task automatic test_backpressure();
      int         n;
      logic       nz;
      logic [I:0] w [4];
      w[0] = 25'h0ABCDEF; w[1] = 25'h1000000; w[2] = 25'h0000FFF; w[3] = 25'h1234567;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      model_clear();
      for (int i = 0; i < 4; i++) begin
         ld_valid = 1'b1;
         ld_data  = w[i];
         ld_last  = (i == 3);
         tick();
         model_write(w[i]);
         if (i < 3) begin
            ld_valid = 1'b0;
            ld_data  = 25'h1DEAD00;
            ld_last  = 1'b1;
            tick();
         end
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      wait_idle(n, nz);
      checks++;
      if (n != 60 || done !== 1'b1) begin
         errors++;
         $display("FAIL bp_fill_len: cycles=%0d done=%b expected 60 1", n, done);
      end
      checks++;
      if (checksum !== exp_checksum || word_count !== exp_count) begin
         errors++;
         $display("FAIL bp_sum: checksum=%h word_count=%0d expected %h %0d", checksum, word_count, exp_checksum, exp_count);
      end
      test_fetch("backpressure");
   endtask

   task automatic test_scan();
      int   n;
      logic nz;
      checks++;
      if (scan_ok !== 1'b0) begin
         errors++;
         $display("FAIL scan_pre: scan_ok=%b expected 0", scan_ok);
      end
      address    = 6'd1;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0;
      wait_idle(n, nz);
      checks++;
      if (n != 65 || nz) begin
         errors++;
         $display("FAIL scan_len: cycles=%0d instr_nonzero=%b expected 65 0", n, nz);
      end
      checks++;
      if (done !== 1'b1 || scan_ok !== 1'b1) begin
         errors++;
         $display("FAIL scan_result: done=%b scan_ok=%b expected 1 1", done, scan_ok);
      end
      tick();
      checks++;
      if (done !== 1'b0 || scan_ok !== 1'b1) begin
         errors++;
         $display("FAIL scan_hold: done=%b scan_ok=%b expected 0 1", done, scan_ok);
      end
   endtask

   task automatic test_reset_midload();
      int   n;
      logic nz;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1'b1;
         ld_data  = 25'h0F0F0F0 + 25'(i);
         tick();
      end
      ld_valid = 1'b1;
      Reset    = 1'b1;
      tick();
      Reset    = 1'b0;
      ld_valid = 1'b0;
      wait_idle(n, nz);
      checks++;
      if (n != 64 || done !== 1'b1) begin
         errors++;
         $display("FAIL midload_fill_len: cycles=%0d done=%b expected 64 1", n, done);
      end
      checks++;
      if (checksum !== '0 || word_count !== '0 || scan_ok !== 1'b0) begin
         errors++;
         $display("FAIL midload_regs: checksum=%h word_count=%0d scan_ok=%b expected 0 0 0", checksum, word_count, scan_ok);
      end
      model_clear();
      test_fetch("reset_midload");
   endtask

   task automatic test_simultaneous_start();
      int   n;
      logic nz;
      load_start = 1'b1;
      scan_start = 1'b1;
      tick();
      load_start = 1'b0;
      scan_start = 1'b0;
      checks++;
      if (ld_ready !== 1'b1 || ready !== 1'b0) begin
         errors++;
         $display("FAIL simul_load_wins: ld_ready=%b ready=%b expected 1 0", ld_ready, ready);
      end
      model_clear();
      ld_valid = 1'b1;
      ld_data  = 25'h0000042;
      ld_last  = 1'b1;
      tick();
      model_write(25'h0000042);
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      wait_idle(n, nz);
      checks++;
      if (n != 63 || checksum !== 25'h0000042 || word_count !== 7'd1) begin
         errors++;
         $display("FAIL simul_load: fill=%0d checksum=%h word_count=%0d expected 63 0000042 1", n, checksum, word_count);
      end
      test_fetch("simultaneous");
   endtask

   initial begin
      test_reset();
      test_short_load();
      test_full_load();
      test_backpressure();
      test_scan();
      test_reset_midload();
      test_simultaneous_start();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
